// File: rtl/rtio_event_scheduler.sv
// Timestamped event scheduler: FIFO of {ts,data}, one-cycle issue at counter.
// RTIO_EVENT_SCHEDULER_LATE_DROP_EN: drop late events instead of issuing them.
module rtio_event_scheduler #(
  parameter int DATA_WIDTH      = 64,
  parameter int FIFO_DEPTH      = 16,
  parameter int FIFO_ADDR_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [63:0]              counter,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [63:0]              in_timestamp,
  input  logic [DATA_WIDTH-1:0]    in_data,
  output logic                     out_valid,
  output logic [63:0]              out_timestamp,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic                     out_late,
  output logic [15:0]              late_count,
  output logic [FIFO_ADDR_WIDTH:0] fifo_level,
  output logic                     fifo_full,
  output logic                     fifo_empty
);

  typedef enum logic [1:0] {
    S_EMPTY,
    S_LOAD,
    S_WAIT,
    S_FIRE
  } state_t;

  localparam logic [FIFO_ADDR_WIDTH:0] LP_DEPTH =
    (FIFO_ADDR_WIDTH+1)'(FIFO_DEPTH);

  state_t r_state;
  state_t w_state_nxt;

  logic [63:0]              r_mem_ts   [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]    r_mem_data [FIFO_DEPTH];
  logic [FIFO_ADDR_WIDTH-1:0] r_wr_ptr;
  logic [FIFO_ADDR_WIDTH-1:0] r_rd_ptr;
  logic [FIFO_ADDR_WIDTH:0] r_level;
  logic [FIFO_ADDR_WIDTH:0] w_level_nxt;
  logic                     r_full;
  logic                     r_empty;
  logic                     r_ready;

  logic [63:0]              r_head_ts;
  logic [DATA_WIDTH-1:0]    r_head_data;
  logic                     r_eval;

  logic                     r_out_valid;
  logic [63:0]              r_out_ts;
  logic [DATA_WIDTH-1:0]    r_out_data;
  logic [15:0]              r_late_count;

  logic w_push;
  logic w_pop;
  logic w_avail;
  logic w_due;
  logic w_issue;
  logic w_late;
  logic w_show;

  assign w_push  = in_valid && r_ready;
  assign w_avail = !r_empty || w_push;
  assign w_due   = start && (counter >= r_head_ts);

  assign w_level_nxt = r_level
    + {{FIFO_ADDR_WIDTH{1'b0}}, w_push}
    - {{FIFO_ADDR_WIDTH{1'b0}}, w_pop};

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_ts[r_wr_ptr]   <= in_timestamp;
      r_mem_data[r_wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_ready  <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_level <= w_level_nxt;
      r_full  <= (w_level_nxt == LP_DEPTH);
      r_empty <= (w_level_nxt == '0);
      r_ready <= (w_level_nxt != LP_DEPTH);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_head_ts   <= '0;
      r_head_data <= '0;
      r_eval      <= 1'b0;
    end else begin
      if (w_pop) begin
        r_head_ts   <= r_mem_ts[r_rd_ptr];
        r_head_data <= r_mem_data[r_rd_ptr];
      end
      // Late check only on the first start-high cycle of each WAIT run
      r_eval <= (r_state == S_WAIT) && start;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_EMPTY;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_EMPTY: if (w_avail) w_state_nxt = S_LOAD;
      S_LOAD:  w_state_nxt = S_WAIT;
      S_WAIT:  if (w_due) w_state_nxt = S_FIRE;
      S_FIRE:  w_state_nxt = w_avail ? S_LOAD : S_EMPTY;
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  always_comb begin
    w_pop   = (r_state == S_LOAD);
    w_issue = 1'b0;
    w_late  = 1'b0;
    if (r_state == S_WAIT && w_due) begin
      w_issue = 1'b1;
      w_late  = !r_eval && (counter > r_head_ts);
    end
`ifdef RTIO_EVENT_SCHEDULER_LATE_DROP_EN
    w_show = w_issue && !w_late;
`else
    w_show = w_issue;
`endif
  end

  // Output registers load on WAIT->FIRE so the pulse lands in FIRE
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid  <= 1'b0;
      r_out_ts     <= '0;
      r_out_data   <= '0;
      r_late_count <= '0;
    end else begin
      r_out_valid <= w_show;
      if (w_show) begin
        r_out_ts   <= r_head_ts;
        r_out_data <= r_head_data;
      end
      if (w_issue && w_late && r_late_count != 16'hFFFF)
        r_late_count <= r_late_count + 16'd1;
    end
  end

`ifdef RTIO_EVENT_SCHEDULER_LATE_DROP_EN
  assign out_late = 1'b0;
`else
  logic r_out_late;

  always_ff @(posedge clk) begin
    if (reset)       r_out_late <= 1'b0;
    else if (w_show) r_out_late <= w_late;
  end

  assign out_late = r_out_late;
`endif

  assign in_ready      = r_ready;
  assign out_valid     = r_out_valid;
  assign out_timestamp = r_out_ts;
  assign out_data      = r_out_data;
  assign late_count    = r_late_count;
  assign fifo_level    = r_level;
  assign fifo_full     = r_full;
  assign fifo_empty    = r_empty;

endmodule

// File: tb/tb_rtio_event_scheduler.sv
// Bench for rtio_event_scheduler: event-time reference model plus directed
// scenarios and randomized traffic.
module tb_rtio_event_scheduler;

  logic        clk;
  logic        reset;
  logic        start;
  logic [63:0] counter;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_timestamp;
  logic [63:0] in_data;
  logic        out_valid;
  logic [63:0] out_timestamp;
  logic [63:0] out_data;
  logic        out_late;
  logic [15:0] late_count;
  logic [4:0]  fifo_level;
  logic        fifo_full;
  logic        fifo_empty;

  rtio_event_scheduler dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .counter      (counter),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_timestamp (in_timestamp),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_timestamp(out_timestamp),
    .out_data     (out_data),
    .out_late     (out_late),
    .late_count   (late_count),
    .fifo_level   (fifo_level),
    .fifo_full    (fifo_full),
    .fifo_empty   (fifo_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int     nchk = 0;
  int     nerr = 0;
  longint cyc  = 0;

  logic        v_reset;
  logic        v_start;
  logic        v_valid;
  logic [63:0] v_cnt;
  logic [63:0] v_ts;
  logic [63:0] v_data;
  int          v_inc;

  typedef struct {
    logic [63:0] ts;
    logic [63:0] d;
    longint      pc;
  } ev_t;

  // model: FIFO contents, head event and the cycle it may first be judged
  ev_t    q[$];
  ev_t    h;
  bit     h_v;
  bit     h_armed;
  longint h_wait;
  longint last_fire;
  bit     m_known;

  bit          e_valid;
  bit          e_late;
  bit          e_full;
  bit          e_empty;
  bit          e_ready;
  logic [63:0] e_ts;
  logic [63:0] e_data;
  logic [15:0] e_lc;
  int          e_lvl;

  int          n_issue;
  logic [63:0] o_ts_q[$];
  logic [63:0] o_cnt_q[$];
  bit          o_late_q[$];

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic compare();
    if (out_valid === 1'b1) begin
      n_issue++;
      o_ts_q.push_back(out_timestamp);
      o_cnt_q.push_back(counter);
      o_late_q.push_back(out_late);
    end
    if (m_known) begin
      chk("out_valid", 64'(out_valid), 64'(e_valid));
      chk("in_ready", 64'(in_ready), 64'(e_ready));
      chk("fifo_level", 64'(fifo_level), 64'(e_lvl));
      chk("fifo_full", 64'(fifo_full), 64'(e_full));
      chk("fifo_empty", 64'(fifo_empty), 64'(e_empty));
      chk("late_count", 64'(late_count), 64'(e_lc));
      if (e_valid) begin
        chk("out_timestamp", out_timestamp, e_ts);
        chk("out_data", out_data, e_data);
        chk("out_late", 64'(out_late), 64'(e_late));
      end
    end
  endtask

  // Event-level rules: an event is judged from max(push+2, prev issue+2);
  // the first start-high cycle of a judging run decides lateness.
  task automatic model();
    bit push;
    bit late;
    if (v_reset) begin
      q.delete();
      h_v = 0; h_armed = 0; last_fire = -10;
      e_valid = 0; e_late = 0; e_ts = '0; e_data = '0; e_lc = '0;
      e_lvl = 0; e_full = 0; e_empty = 1; e_ready = 1;
      m_known = 1;
      return;
    end
    if (!m_known) return;
    push = v_valid && e_ready;
    e_valid = 0;
    if (h_v && cyc >= h_wait) begin
      if (v_start) begin
        late = !h_armed && (v_cnt > h.ts);
        if (v_cnt >= h.ts) begin
          h_v = 0;
          last_fire = cyc + 1;
          if (late && e_lc != 16'hFFFF) e_lc = e_lc + 16'd1;
`ifdef RTIO_EVENT_SCHEDULER_LATE_DROP_EN
          if (!late) begin
            e_valid = 1; e_ts = h.ts; e_data = h.d; e_late = 0;
          end
`else
          e_valid = 1; e_ts = h.ts; e_data = h.d; e_late = late;
`endif
        end else begin
          h_armed = 1;
        end
      end else begin
        h_armed = 0;
      end
    end
    if (!h_v && q.size() > 0 && cyc >= q[0].pc + 1
        && cyc >= last_fire + 1) begin
      h = q.pop_front();
      h_v = 1;
      h_wait = cyc + 1;
      h_armed = 0;
    end
    if (push) q.push_back('{ts: v_ts, d: v_data, pc: cyc});
    e_lvl   = q.size();
    e_full  = (e_lvl == 16);
    e_empty = (e_lvl == 0);
    e_ready = !e_full;
  endtask

  task automatic step();
    @(negedge clk);
    compare();
    reset        = v_reset;
    start        = v_start;
    counter      = v_cnt;
    in_valid     = v_valid;
    in_timestamp = v_ts;
    in_data      = v_data;
    model();
    v_cnt = v_cnt + 64'(v_inc);
    cyc++;
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic push_ev(logic [63:0] ts, logic [63:0] d);
    v_valid = 1; v_ts = ts; v_data = d;
    step();
    v_valid = 0;
  endtask

  task automatic reset_dut();
    v_reset = 1; v_valid = 0;
    step();
    v_reset = 0;
    step();
    n_issue = 0;
    o_ts_q.delete(); o_cnt_q.delete(); o_late_q.delete();
  endtask

  task automatic wait_issue(int target, int budget);
    int k = 0;
    while (n_issue < target && k < budget) begin
      step();
      k++;
    end
    chk("issue_count", 64'(n_issue), 64'(target));
  endtask

  task automatic chk_issue(string nm, int k, logic [63:0] ts, bit late);
    if (o_ts_q.size() > k) begin
      chk({nm, "_ts"}, o_ts_q[k], ts);
      chk({nm, "_late"}, 64'(o_late_q[k]), 64'(late));
    end else begin
      chk({nm, "_missing"}, 64'(o_ts_q.size()), 64'(k + 1));
    end
  endtask

  initial begin
    reset = 1; start = 0; counter = '0; in_valid = 0;
    in_timestamp = '0; in_data = '0;
    v_reset = 1; v_start = 0; v_valid = 0; v_cnt = '0;
    v_ts = '0; v_data = '0; v_inc = 1;
    m_known = 0; n_issue = 0;

    // reset values
    reset_dut();
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_late", 64'(out_late), 64'd0);
    chk("rst_out_ts", out_timestamp, 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_late_count", 64'(late_count), 64'd0);
    chk("rst_level", 64'(fifo_level), 64'd0);
    chk("rst_empty", 64'(fifo_empty), 64'd1);
    chk("rst_full", 64'(fifo_full), 64'd0);

    // on-time issue at ts=100
    v_cnt = 0; v_start = 1;
    push_ev(64'd100, 64'hA5);
    wait_issue(1, 200);
    chk_issue("t1", 0, 64'd100, 1'b0);
    if (o_cnt_q.size() > 0) chk("t1_cnt", o_cnt_q[0], 64'd100);
    chk("t1_late_count", 64'(late_count), 64'd0);

    // late event
    reset_dut();
    v_cnt = 50; v_start = 1;
    push_ev(64'd10, 64'h5A);
`ifdef RTIO_EVENT_SCHEDULER_LATE_DROP_EN
    run(10);
    chk("t2_no_issue", 64'(n_issue), 64'd0);
`else
    wait_issue(1, 20);
    chk_issue("t2", 0, 64'd10, 1'b1);
`endif
    chk("t2_late_count", 64'(late_count), 64'd1);

    // fill to capacity with start low, then drain in order
    reset_dut();
    v_cnt = 0; v_start = 0;
    for (int i = 0; i < 17; i++) begin
      v_valid = 1; v_ts = 64'(1000 + 10 * i); v_data = 64'(i);
      step();
    end
    v_valid = 0;
    step();
    chk("t3_full", 64'(fifo_full), 64'd1);
    chk("t3_level", 64'(fifo_level), 64'd16);
    chk("t3_ready", 64'(in_ready), 64'd0);
    v_start = 1; v_cnt = 990;
    wait_issue(17, 400);
    for (int i = 0; i < 17; i++)
      chk_issue("t3_order", i, 64'(1000 + 10 * i), 1'b0);
    chk("t3_ready_back", 64'(in_ready), 64'd1);

    // closely spaced timestamps
    reset_dut();
    v_cnt = 150; v_start = 1;
    push_ev(64'd200, 64'h200);
    push_ev(64'd201, 64'h201);
    push_ev(64'd203, 64'h203);
    run(60);
    chk_issue("t4_first", 0, 64'd200, 1'b0);
`ifndef RTIO_EVENT_SCHEDULER_LATE_DROP_EN
    chk_issue("t4_second", 1, 64'd201, 1'b1);
`endif

    // start held low across a timestamp
    reset_dut();
    v_cnt = 200; v_start = 1;
    push_ev(64'd300, 64'h300);
    push_ev(64'd400, 64'h400);
    while (v_cnt < 250) step();
    v_start = 0;
    while (v_cnt < 350) step();
    v_start = 1;
    run(80);
`ifdef RTIO_EVENT_SCHEDULER_LATE_DROP_EN
    chk_issue("t5_only", 0, 64'd400, 1'b0);
`else
    chk_issue("t5_late", 0, 64'd300, 1'b1);
    chk_issue("t5_ontime", 1, 64'd400, 1'b0);
`endif
    chk("t5_late_count", 64'(late_count), 64'd1);

    // reset mid-operation
    reset_dut();
    v_cnt = 0; v_start = 0;
    for (int i = 0; i < 6; i++) push_ev(64'(5000 + i), 64'(i));
    run(4);
    chk("t6_level", 64'(fifo_level), 64'd5);
    reset_dut();
    v_start = 1; v_cnt = 6000;
    run(20);
    chk("t6_no_issue", 64'(n_issue), 64'd0);
    chk("t6_level0", 64'(fifo_level), 64'd0);
    chk("t6_late0", 64'(late_count), 64'd0);
    chk("t6_ready", 64'(in_ready), 64'd1);

    // randomized traffic
    reset_dut();
    v_cnt = 0;
    for (int i = 0; i < 4000; i++) begin
      if (((i / 400) % 2) == 1) begin
        v_start = ($urandom_range(0, 7) == 0);
        v_valid = ($urandom_range(0, 1) == 0);
      end else begin
        v_start = ($urandom_range(0, 7) != 0);
        v_valid = ($urandom_range(0, 2) == 0);
      end
      v_ts = v_cnt + 64'($urandom_range(0, 40));
      if ($urandom_range(0, 3) == 0)
        v_ts = (v_cnt > 8) ? v_cnt - 64'd8 : 64'd0;
      v_data  = {$urandom, $urandom};
      v_inc   = $urandom_range(0, 2);
      v_reset = ($urandom_range(0, 999) == 0);
      step();
    end
    v_reset = 0; v_valid = 0; v_start = 1; v_inc = 1;
    run(300);
    chk("rand_drained", 64'(fifo_empty), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
